// File: rtl/servo_pwm_axil_multich_if.sv
// AXI4-Lite slave bundle for the multichannel servo PWM block.
// Signal names follow the PS interconnect naming.
interface servo_pwm_axil_multich_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] S_AXI_AWADDR;
  logic              S_AXI_AWVALID;
  logic              S_AXI_AWREADY;
  logic [31:0]       S_AXI_WDATA;
  logic [3:0]        S_AXI_WSTRB;
  logic              S_AXI_WVALID;
  logic              S_AXI_WREADY;
  logic [1:0]        S_AXI_BRESP;
  logic              S_AXI_BVALID;
  logic              S_AXI_BREADY;
  logic [ADDR_W-1:0] S_AXI_ARADDR;
  logic              S_AXI_ARVALID;
  logic              S_AXI_ARREADY;
  logic [31:0]       S_AXI_RDATA;
  logic [1:0]        S_AXI_RRESP;
  logic              S_AXI_RVALID;
  logic              S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID,
    input  S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY, S_AXI_RDATA,
    output S_AXI_RRESP, S_AXI_RVALID
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID,
    output S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY, S_AXI_RDATA,
    input  S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/servo_pwm_axil_multich.sv
// N-channel servo PWM with shared prescaler/period, per-channel
// slew-limited pulse widths and an AXI4-Lite register file.
module servo_pwm_axil_multich #(
  parameter int N_CH               = 8,
  parameter int CNT_W              = 20,
  parameter int C_S_AXI_ADDR_WIDTH = 8
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  servo_pwm_axil_multich_if.slave s_axi,
  output logic [N_CH-1:0]         pwm_out
);
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  typedef logic [CNT_W-1:0] cnt_t;

  logic [N_CH-1:0] ctrl_q;
  cnt_t presc_q, period_q, step_q;
  cnt_t tgt_q [N_CH];
  cnt_t cur_q [N_CH];
  cnt_t cur_d [N_CH];
  cnt_t psc_q, pc_q, per_s_q;
  logic [N_CH-1:0] pwm_q, pwm_d;

  logic awrdy_q, bvalid_q, arrdy_q, rvalid_q;
  logic [1:0] bresp_q, rresp_q;
  logic [31:0] rdata_q;

  logic [AW-1:0] wa, ra;
  logic [32:0] wr_old, rd_sel;
  logic [31:0] wm;
  logic wr_fire, rd_fire, wr_hit;
  logic we_ctrl, we_presc, we_per, we_step;
  logic [N_CH-1:0] we_tgt;
  logic tick, bnd;

  // {slverr, data}; bits above the register width read as zero
  function automatic logic [32:0] rd_mux(input logic [AW-1:0] w);
    logic [32:0] r;
    r = '0;
    if (w == AW'(0)) r[N_CH-1:0] = ctrl_q;
    else if (w == AW'(1)) r[CNT_W-1:0] = presc_q;
    else if (w == AW'(2)) r[CNT_W-1:0] = period_q;
    else if (w == AW'(3)) r[CNT_W-1:0] = step_q;
    else begin
      r[32] = 1'b1;
      for (int k = 0; k < N_CH; k++) begin
        if (w == AW'(4 + 2*k)) begin
          r[32] = 1'b0;
          r[CNT_W-1:0] = tgt_q[k];
        end
        if (w == AW'(5 + 2*k)) begin
          r[32] = 1'b0;
          r[CNT_W-1:0] = cur_q[k];
        end
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] merge(
    input logic [31:0] o,
    input logic [31:0] d,
    input logic [3:0]  s
  );
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  assign wa = s_axi.S_AXI_AWADDR >> 2;
  assign ra = s_axi.S_AXI_ARADDR >> 2;
  assign wr_old = rd_mux(wa);
  assign rd_sel = rd_mux(ra);
  assign wm = merge(wr_old[31:0], s_axi.S_AXI_WDATA,
                    s_axi.S_AXI_WSTRB);

  assign wr_fire = awrdy_q & s_axi.S_AXI_AWVALID
                 & s_axi.S_AXI_WVALID;
  assign rd_fire = arrdy_q & s_axi.S_AXI_ARVALID;

  always_comb begin
    we_ctrl  = wr_fire & (wa == AW'(0));
    we_presc = wr_fire & (wa == AW'(1));
    we_per   = wr_fire & (wa == AW'(2));
    we_step  = wr_fire & (wa == AW'(3));
    for (int k = 0; k < N_CH; k++)
      we_tgt[k] = wr_fire & (wa == AW'(4 + 2*k));
    wr_hit = we_ctrl | we_presc | we_per | we_step | (|we_tgt);
  end

  assign s_axi.S_AXI_AWREADY = awrdy_q;
  assign s_axi.S_AXI_WREADY  = awrdy_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arrdy_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      awrdy_q  <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= 2'b00;
      arrdy_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rresp_q  <= 2'b00;
      rdata_q  <= '0;
    end else begin
      awrdy_q <= s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID
               & ~bvalid_q & ~awrdy_q;
      if (wr_fire) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_hit ? 2'b00 : 2'b10;
      end else if (bvalid_q && s_axi.S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
      arrdy_q <= s_axi.S_AXI_ARVALID & ~rvalid_q & ~arrdy_q;
      if (rd_fire) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_sel[32] ? 32'h0 : rd_sel[31:0];
        rresp_q  <= rd_sel[32] ? 2'b10 : 2'b00;
      end else if (rvalid_q && s_axi.S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      ctrl_q   <= '0;
      presc_q  <= '0;
      period_q <= '0;
      step_q   <= '0;
      for (int k = 0; k < N_CH; k++) tgt_q[k] <= '0;
    end else begin
      if (we_ctrl)  ctrl_q   <= wm[N_CH-1:0];
      if (we_presc) presc_q  <= wm[CNT_W-1:0];
      if (we_per)   period_q <= wm[CNT_W-1:0];
      if (we_step)  step_q   <= wm[CNT_W-1:0];
      for (int k = 0; k < N_CH; k++)
        if (we_tgt[k]) tgt_q[k] <= wm[CNT_W-1:0];
    end
  end

  // >= keeps the prescaler from running off if PRESCALE shrinks
  assign tick = (psc_q >= presc_q);
  assign bnd  = tick & ((per_s_q == '0) | (pc_q == per_s_q - 1'b1));

  // The slew target is the value being shadowed at this boundary
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      cur_d[k] = cur_q[k];
      if (bnd && ctrl_q[k]) begin
        if (tgt_q[k] > cur_q[k])
          cur_d[k] = (step_q == '0 || tgt_q[k] - cur_q[k] <= step_q)
                   ? tgt_q[k] : cur_q[k] + step_q;
        else
          cur_d[k] = (step_q == '0 || cur_q[k] - tgt_q[k] <= step_q)
                   ? tgt_q[k] : cur_q[k] - step_q;
      end
      pwm_d[k] = ctrl_q[k] & (per_s_q != '0) & (pc_q < cur_q[k]);
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      psc_q   <= '0;
      pc_q    <= '0;
      per_s_q <= '0;
      pwm_q   <= '0;
      for (int k = 0; k < N_CH; k++) cur_q[k] <= '0;
    end else begin
      psc_q <= tick ? '0 : psc_q + 1'b1;
      if (bnd) begin
        pc_q    <= '0;
        per_s_q <= period_q;
      end else if (tick) begin
        pc_q <= pc_q + 1'b1;
      end
      for (int k = 0; k < N_CH; k++) cur_q[k] <= cur_d[k];
      pwm_q <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;
endmodule

// File: tb/tb_servo_pwm_axil_multich.sv
// Directed bench for servo_pwm_axil_multich: register file,
// PWM timing, slew limiting, shadowing, errors and reset.
module tb_servo_pwm_axil_multich;
  localparam int N_CH = 8;
  localparam int CNT_W = 20;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N_CH-1:0] pwm;
  always #5 clk = ~clk;

  servo_pwm_axil_multich_if #(.ADDR_W(AW)) bus ();

  servo_pwm_axil_multich #(
    .N_CH(N_CH), .CNT_W(CNT_W), .C_S_AXI_ADDR_WIDTH(AW)
  ) dut (
    .ACLK(clk), .ARESET(rst), .s_axi(bus), .pwm_out(pwm)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int pw_q[$];
  int pw_cnt = 0;
  always @(negedge clk) begin
    if (pwm[0]) pw_cnt++;
    else if (pw_cnt != 0) begin
      pw_q.push_back(pw_cnt);
      pw_cnt = 0;
    end
  end

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp);
    bit ok;
    @(negedge clk);
    bus.S_AXI_AWADDR = a;
    bus.S_AXI_WDATA = d;
    bus.S_AXI_WSTRB = s;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID = 1'b1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.S_AXI_AWREADY) begin ok = 1; break; end
    end
    if (!ok) check("aw_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID = 1'b0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.S_AXI_BVALID) begin ok = 1; break; end
    end
    if (!ok) check("b_timeout", 0, 1);
    resp = bus.S_AXI_BRESP;
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d,
                          output logic [1:0] resp);
    bit ok;
    @(negedge clk);
    bus.S_AXI_ARADDR = a;
    bus.S_AXI_ARVALID = 1'b1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.S_AXI_ARREADY) begin ok = 1; break; end
    end
    if (!ok) check("ar_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.S_AXI_ARVALID = 1'b0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.S_AXI_RVALID) begin ok = 1; break; end
    end
    if (!ok) check("r_timeout", 0, 1);
    d = bus.S_AXI_RDATA;
    resp = bus.S_AXI_RRESP;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic [1:0] r;
    axi_write(a, d, 4'hF, r);
    check($sformatf("wr_resp_%02h", a), 32'(r), 0);
  endtask

  task automatic count_high(input int n, output int h);
    h = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (pwm[0]) h++;
    end
  endtask

  task automatic wait_rise(output bit ok);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!pwm[0]) break;
    end
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (pwm[0]) begin ok = 1; break; end
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, last;
    logic [1:0] r;
    logic [31:0] exp3 [3];
    logic [7:0] rst_addr [6];
    int h;
    bit ok;
    bus.S_AXI_AWADDR = '0;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = '0;
    bus.S_AXI_WSTRB = '0;
    bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b1;
    bus.S_AXI_ARADDR = '0;
    bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_pwm", 32'(pwm), 0);
    check("rst_bvalid", 32'(bus.S_AXI_BVALID), 0);
    check("rst_rvalid", 32'(bus.S_AXI_RVALID), 0);
    check("rst_awready", 32'(bus.S_AXI_AWREADY), 0);
    check("rst_rdata", bus.S_AXI_RDATA, 0);
    rst = 1'b0;

    // 1: register readback and write backpressure
    for (int i = 0; i < 4; i++) wr(8'(4*i), 32'(i + 1));
    for (int i = 0; i < 4; i++) begin
      axi_read(8'(4*i), d, r);
      check($sformatf("t1_rd_%0d", i), d, 32'(i + 1));
      check($sformatf("t1_rresp_%0d", i), 32'(r), 0);
    end
    bus.S_AXI_BREADY = 1'b0;
    axi_write(8'h0C, 32'h55, 4'hF, r);
    @(negedge clk);
    bus.S_AXI_AWADDR = 8'h0C;
    bus.S_AXI_WDATA = 32'h99;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID = 1'b1;
    h = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.S_AXI_BVALID && !bus.S_AXI_AWREADY) h++;
    end
    check("t1_bp_hold", 32'(h), 5);
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b1;
    repeat (2) @(negedge clk);
    check("t1_bvalid_clr", 32'(bus.S_AXI_BVALID), 0);
    axi_read(8'h0C, d, r);
    check("t1_step_once", d, 32'h55);

    // 2: 3-of-10 duty at PRESCALE=0
    wr(8'h04, 0);
    wr(8'h08, 10);
    wr(8'h0C, 0);
    wr(8'h10, 3);
    wr(8'h00, 1);
    repeat (40) @(negedge clk);
    count_high(20, h);
    check("t2_duty", 32'(h), 6);
    axi_read(8'h14, d, r);
    check("t2_cur0", d, 3);

    // 3: slew 0 -> 20 -> 40 -> 50 on channel 1
    wr(8'h04, 1);
    wr(8'h08, 100);
    wr(8'h0C, 20);
    wr(8'h18, 50);
    wr(8'h00, 2);
    count_high(20, h);
    check("t3_ch0_off", 32'(h), 0);
    exp3 = '{32'd20, 32'd40, 32'd50};
    last = 0;
    for (int e = 0; e < 3; e++) begin
      d = last;
      for (int i = 0; i < 400 && d == last; i++) axi_read(8'h1C, d, r);
      check($sformatf("t3_cur1_%0d", e), d, exp3[e]);
      last = d;
    end
    repeat (450) @(negedge clk);
    axi_read(8'h1C, d, r);
    check("t3_cur1_hold", d, 50);

    // 4: target shadowing and PERIOD=0
    wr(8'h04, 0);
    wr(8'h08, 10);
    wr(8'h0C, 0);
    wr(8'h10, 3);
    wr(8'h00, 1);
    repeat (150) @(negedge clk);
    wait_rise(ok);
    check("t4_rise", 32'(ok), 1);
    pw_q.delete();
    wr(8'h10, 7);
    repeat (30) @(negedge clk);
    check("t4_w_cur", pw_q.size() > 0 ? 32'(pw_q[0]) : 32'hFFFF_FFFF, 3);
    check("t4_w_next", pw_q.size() > 1 ? 32'(pw_q[1]) : 32'hFFFF_FFFF, 7);
    wr(8'h08, 0);
    repeat (30) @(negedge clk);
    count_high(20, h);
    check("t4_per0", 32'(h), 0);

    // 5: error responses, strobes, width clipping
    axi_read(8'hFC, d, r);
    check("t5_rresp", 32'(r), 2);
    check("t5_rdata", d, 0);
    axi_read(8'h50, d, r);
    check("t5_rresp_hi", 32'(r), 2);
    axi_write(8'h14, 32'h123, 4'hF, r);
    check("t5_bresp_ro", 32'(r), 2);
    axi_read(8'h14, d, r);
    check("t5_cur0", d, 7);
    check("t5_cur0_resp", 32'(r), 0);
    axi_write(8'h50, 32'h1, 4'hF, r);
    check("t5_bresp_hi", 32'(r), 2);
    axi_write(8'h08, 32'hAABBCCDD, 4'b0001, r);
    check("t5_strb_resp", 32'(r), 0);
    axi_read(8'h08, d, r);
    check("t5_strb", d, 32'hDD);
    wr(8'h04, 32'hFFFF_FFFF);
    axi_read(8'h04, d, r);
    check("t5_clip", d, 32'h000F_FFFF);
    wr(8'h00, 32'hFFFF_FFFF);
    axi_read(8'h00, d, r);
    check("t5_ctrl_clip", d, 32'hFF);

    // 6: reset mid-period with a pending response
    wr(8'h04, 0);
    wr(8'h00, 1);
    wr(8'h08, 10);
    repeat (300) @(negedge clk);
    wait_rise(ok);
    check("t6_rise", 32'(ok), 1);
    bus.S_AXI_BREADY = 1'b0;
    axi_write(8'h0C, 32'h77, 4'hF, r);
    check("t6_bpend", 32'(bus.S_AXI_BVALID), 1);
    #1 rst = 1'b1;
    @(negedge clk);
    check("t6_pwm", 32'(pwm), 0);
    check("t6_bvalid", 32'(bus.S_AXI_BVALID), 0);
    rst = 1'b0;
    bus.S_AXI_BREADY = 1'b1;
    rst_addr = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14};
    for (int i = 0; i < 6; i++) begin
      axi_read(rst_addr[i], d, r);
      check($sformatf("t6_zero_%02h", rst_addr[i]), d, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
